// File: rtl/i2c_reg_sequencer.sv
`timescale 1ns / 1ps
// i2c_reg_sequencer
// Runs a single I2C register write or register read on top of a byte engine.
// The sequencer drives START, repeated-START and STOP itself, hands each
// byte to the engine with a one-cycle start pulse, checks the ACK after
// every written byte and returns one response pulse per command.
module i2c_reg_sequencer #(
    parameter int HALF_PERIOD  = 350,
    parameter int BYTE_TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_dev_addr,
    input  logic [7:0] cmd_reg_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic       eng_start,
    output logic       eng_mode_w_r,
    output logic [7:0] eng_data,
    input  logic [7:0] eng_read_data,
    input  logic       eng_receive_ack,
    input  logic       eng_idle,
    output logic       bus_own,
    output logic       bus_scl,
    output logic       bus_sda_low
);

    localparam int PHASE_W = ($clog2(HALF_PERIOD) > 9) ? $clog2(HALF_PERIOD) : 9;
    localparam int TO_W    = $clog2(BYTE_TIMEOUT + 1);

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_LOAD,        // byte and mode presented one cycle ahead of the start pulse
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_R1,
        ST_R2,
        ST_R3,
        ST_R4,
        ST_P1,
        ST_P2,
        ST_P3,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        BYTE_ADDR_W,
        BYTE_REG,
        BYTE_DATA,
        BYTE_ADDR_R,
        BYTE_READ
    } byte_sel_t;

    state_t    state, state_next;
    byte_sel_t byte_sel, byte_next;

    logic               rw_q;
    logic [6:0]         dev_q;
    logic [7:0]         reg_q;
    logic [7:0]         wdata_q;
    logic               nack_q;
    logic               to_q;
    logic [PHASE_W-1:0] phase_cnt;
    logic [TO_W-1:0]    to_cnt;

    logic phase_done;
    logic byte_timeout;
    logic byte_done;
    logic byte_abort;
    logic write_nack;
    logic cmd_accept;

    assign cmd_accept   = (state == ST_IDLE) && cmd_valid;
    assign phase_done   = (phase_cnt == PHASE_W'(HALF_PERIOD - 1));
    assign byte_timeout = (to_cnt == TO_W'(BYTE_TIMEOUT));
    assign byte_done    = (state == ST_WAIT_DONE) && eng_idle;
    assign write_nack   = byte_done && (byte_sel != BYTE_READ) && eng_receive_ack;
    // A finishing byte wins over a timeout that expires in the same cycle.
    assign byte_abort   = byte_timeout &&
                          (((state == ST_WAIT_BUSY) && eng_idle) ||
                           ((state == ST_WAIT_DONE) && !eng_idle));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Which byte follows the current one once it completes with ACK.
    always_comb begin
        byte_next = byte_sel;
        case (byte_sel)
            BYTE_ADDR_W: byte_next = BYTE_REG;
            BYTE_REG:    byte_next = rw_q ? BYTE_ADDR_R : BYTE_DATA;
            BYTE_ADDR_R: byte_next = BYTE_READ;
            default:     byte_next = byte_sel;
        endcase
    end

    // Next-state logic: bus condition phases, byte handshake and abort paths.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            ST_IDLE:      if (cmd_valid) state_next = ST_S1;
            ST_S1:        if (phase_done) state_next = ST_S2;
            ST_S2:        if (phase_done) state_next = ST_LOAD;
            ST_LOAD:      state_next = ST_ISSUE;
            // An engine already busy during the start pulse counts as busy seen.
            ST_ISSUE:     state_next = eng_idle ? ST_WAIT_BUSY : ST_WAIT_DONE;
            ST_WAIT_BUSY: begin
                if (!eng_idle)       state_next = ST_WAIT_DONE;
                else if (byte_abort) state_next = ST_P1;
            end
            ST_WAIT_DONE: begin
                if (byte_done) begin
                    if (write_nack) begin
                        state_next = ST_P1;
                    end else begin
                        case (byte_sel)
                            BYTE_REG:  state_next = rw_q ? ST_R1 : ST_LOAD;
                            BYTE_DATA: state_next = ST_P1;
                            BYTE_READ: state_next = ST_P1;
                            default:   state_next = ST_LOAD;
                        endcase
                    end
                end else if (byte_abort) begin
                    state_next = ST_P1;
                end
            end
            ST_R1:        if (phase_done) state_next = ST_R2;
            ST_R2:        if (phase_done) state_next = ST_R3;
            ST_R3:        if (phase_done) state_next = ST_R4;
            ST_R4:        if (phase_done) state_next = ST_LOAD;
            ST_P1:        if (phase_done) state_next = ST_P2;
            ST_P2:        if (phase_done) state_next = ST_P3;
            ST_P3:        if (phase_done) state_next = ST_DONE;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Phase and byte-timeout counters, both saturating.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            if (state_next != state)   phase_cnt <= '0;
            else if (phase_cnt != '1)  phase_cnt <= phase_cnt + PHASE_W'(1);

            if ((state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE)) begin
                if (!byte_timeout) to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end
        end
    end

    // Command capture, byte progression, result flags and read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rw_q      <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            byte_sel  <= BYTE_ADDR_W;
            nack_q    <= 1'b0;
            to_q      <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (cmd_accept) begin
                rw_q     <= cmd_rw;
                dev_q    <= cmd_dev_addr;
                reg_q    <= cmd_reg_addr;
                wdata_q  <= cmd_wdata;
                byte_sel <= BYTE_ADDR_W;
                nack_q   <= 1'b0;
                to_q     <= 1'b0;
            end
            if (byte_done) begin
                byte_sel <= byte_next;
                if (byte_sel == BYTE_READ) rsp_rdata <= eng_read_data;
                else if (eng_receive_ack)  nack_q    <= 1'b1;
            end
            if (byte_abort) begin
                nack_q <= 1'b1;
                to_q   <= 1'b1;
            end
        end
    end

    // Outputs decoded from the current state (bus levels, engine handshake, response).
    always_comb begin
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_nack     = 1'b0;
        rsp_timeout  = 1'b0;
        eng_start    = 1'b0;
        eng_mode_w_r = 1'b0;
        eng_data     = 8'h00;
        bus_own      = 1'b1;
        bus_scl      = 1'b1;
        bus_sda_low  = 1'b0;
        case (state)
            ST_IDLE:      cmd_ready = 1'b1;
            ST_S1:        bus_sda_low = 1'b1;
            ST_S2:        begin bus_scl = 1'b0; bus_sda_low = 1'b1; end
            ST_LOAD,
            ST_WAIT_BUSY,
            ST_WAIT_DONE: begin bus_own = 1'b0; bus_scl = 1'b0; end
            ST_ISSUE:     begin bus_own = 1'b0; bus_scl = 1'b0; eng_start = 1'b1; end
            ST_R1:        bus_scl = 1'b0;
            ST_R3:        bus_sda_low = 1'b1;
            ST_R4:        begin bus_scl = 1'b0; bus_sda_low = 1'b1; end
            ST_P1:        begin bus_scl = 1'b0; bus_sda_low = 1'b1; end
            ST_P2:        bus_sda_low = 1'b1;
            ST_DONE:      begin rsp_valid = 1'b1; rsp_nack = nack_q; rsp_timeout = to_q; end
            default:      ;
        endcase
        if ((state == ST_LOAD) || (state == ST_ISSUE) ||
            (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE)) begin
            case (byte_sel)
                BYTE_ADDR_W: begin eng_mode_w_r = 1'b1; eng_data = {dev_q, 1'b0}; end
                BYTE_REG:    begin eng_mode_w_r = 1'b1; eng_data = reg_q; end
                BYTE_DATA:   begin eng_mode_w_r = 1'b1; eng_data = wdata_q; end
                BYTE_ADDR_R: begin eng_mode_w_r = 1'b1; eng_data = {dev_q, 1'b1}; end
                default:     begin eng_mode_w_r = 1'b0; eng_data = 8'h00; end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
`timescale 1ns / 1ps
// Bench for i2c_reg_sequencer: a reactive byte-engine model, a bus/byte
// monitor, a table of register transactions and hand-written reset and
// back-to-back sequences.
module tb_i2c_reg_sequencer;

    localparam int HALF_PERIOD  = 350;
    localparam int BYTE_TIMEOUT = 20000;
    localparam int RSP_BOUND    = 30000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       rsp_timeout;
    logic       eng_start;
    logic       eng_mode_w_r;
    logic [7:0] eng_data;
    logic [7:0] eng_read_data;
    logic       eng_receive_ack;
    logic       eng_idle;
    logic       bus_own;
    logic       bus_scl;
    logic       bus_sda_low;

    always #10 clk = ~clk;

    i2c_reg_sequencer #(
        .HALF_PERIOD (HALF_PERIOD),
        .BYTE_TIMEOUT(BYTE_TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rw         (cmd_rw),
        .cmd_dev_addr   (cmd_dev_addr),
        .cmd_reg_addr   (cmd_reg_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_nack       (rsp_nack),
        .rsp_timeout    (rsp_timeout),
        .eng_start      (eng_start),
        .eng_mode_w_r   (eng_mode_w_r),
        .eng_data       (eng_data),
        .eng_read_data  (eng_read_data),
        .eng_receive_ack(eng_receive_ack),
        .eng_idle       (eng_idle),
        .bus_own        (bus_own),
        .bus_scl        (bus_scl),
        .bus_sda_low    (bus_sda_low)
    );

    typedef struct {
        logic            rw;
        logic [6:0]      dev;
        logic [7:0]      reg_addr;
        logic [7:0]      wdata;
        int              nack_idx;
        bit              hang;
        bit              early;
        logic [7:0]      model_rdata;
        bit              exp_nack;
        bit              exp_to;
        logic [7:0]      exp_rdata;
        int              exp_nbytes;
        logic [3:0][8:0] exp_bytes;
    } vec_t;

    typedef struct {
        logic [2:0] key;
        int         len;
    } seg_t;

    typedef struct {
        logic [8:0] val;
        int         seg;
    } byte_rec_t;

    int total = 0;
    int bad   = 0;

    // Engine model knobs.
    int         model_nack_idx = -1;
    bit         model_hang     = 1'b0;
    bit         model_early    = 1'b0;
    logic [7:0] model_rdata    = 8'h00;
    int         model_byte_cnt = 0;

    // Monitor state.
    bit          mon_en = 1'b0;
    seg_t        seg_q[$];
    byte_rec_t   byte_q[$];
    logic [2:0]  cur_key;
    int          cur_len = 0;
    logic [8:0]  prev_byte = '0;
    logic        prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                                input logic [7:0] wd, input int nidx, input bit hang,
                                input bit early, input logic [7:0] mrd, input bit en,
                                input bit eto, input logic [7:0] erd, input int nb,
                                input logic [8:0] b0, input logic [8:0] b1,
                                input logic [8:0] b2, input logic [8:0] b3);
        vec_t v;
        v.rw = rw; v.dev = dev; v.reg_addr = ra; v.wdata = wd;
        v.nack_idx = nidx; v.hang = hang; v.early = early; v.model_rdata = mrd;
        v.exp_nack = en; v.exp_to = eto; v.exp_rdata = erd; v.exp_nbytes = nb;
        v.exp_bytes[0] = b0; v.exp_bytes[1] = b1; v.exp_bytes[2] = b2; v.exp_bytes[3] = b3;
        return v;
    endfunction

    // Byte engine model: reacts to each start pulse, goes busy, then reports ACK/data.
    initial begin
        int idx;
        eng_idle        = 1'b1;
        eng_receive_ack = 1'b0;
        eng_read_data   = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_start === 1'b1 && !model_hang) begin
                idx = model_byte_cnt;
                model_byte_cnt++;
                if (model_early) begin
                    eng_idle = 1'b0;
                    @(posedge clk);
                    #1;
                end else begin
                    @(posedge clk);
                    #1 eng_idle = 1'b0;
                    repeat (6) @(posedge clk);
                    #1;
                end
                if (eng_mode_w_r) begin
                    eng_receive_ack = (idx == model_nack_idx);
                end else begin
                    eng_receive_ack = 1'b1;   // master NACK after the read byte
                    eng_read_data   = model_rdata;
                end
                eng_idle = 1'b1;
            end
        end
    end

    // Monitor: run-length trace of bus conditions and log of issued bytes.
    initial begin
        logic [2:0] key;
        seg_t       s;
        byte_rec_t  b;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (rsp_valid === 1'b1) begin
                    if (cur_len != 0) begin
                        s.key = cur_key; s.len = cur_len; seg_q.push_back(s);
                    end
                    cur_len = 0;
                    mon_en  = 1'b0;
                end else begin
                    key = {bus_own, bus_own & bus_scl, bus_own & bus_sda_low};
                    if (cur_len != 0 && key == cur_key) begin
                        cur_len++;
                    end else begin
                        if (cur_len != 0) begin
                            s.key = cur_key; s.len = cur_len; seg_q.push_back(s);
                        end
                        cur_key = key;
                        cur_len = 1;
                    end
                    if (eng_start === 1'b1) begin
                        b.val = {eng_mode_w_r, eng_data};
                        b.seg = seg_q.size();
                        byte_q.push_back(b);
                        check("eng byte setup before start", 32'(b.val), 32'(prev_byte));
                        check("eng_start single cycle", 32'(prev_start), 32'd0);
                    end
                end
            end
            prev_byte  = {eng_mode_w_r, eng_data};
            prev_start = eng_start;
        end
    end

    task automatic mon_start();
        seg_q.delete();
        byte_q.delete();
        cur_len = 0;
        mon_en  = 1'b1;
    endtask

    task automatic drive_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd);
        cmd_rw       = rw;
        cmd_dev_addr = dev;
        cmd_reg_addr = ra;
        cmd_wdata    = wd;
    endtask

    task automatic wait_rsp(input string name, output bit got, output logic [9:0] rsp);
        got = 1'b0;
        rsp = '0;
        for (int c = 0; c < RSP_BOUND && !got; c++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                rsp = {rsp_nack, rsp_timeout, rsp_rdata};
            end
        end
        if (!got) begin
            check({name, " rsp_valid within bound"}, 32'd0, 32'd1);
            mon_en = 1'b0;
        end
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        bit         got;
        logic [9:0] rsp;
        int         exp_keys[$];
        int         n;
        string      nm;
        model_nack_idx = v.nack_idx;
        model_hang     = v.hang;
        model_early    = v.early;
        model_rdata    = v.model_rdata;
        model_byte_cnt = 0;
        @(negedge clk);
        drive_cmd(v.rw, v.dev, v.reg_addr, v.wdata);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        mon_start();
        wait_rsp($sformatf("v%0d", vi), got, rsp);
        if (!got) return;
        check($sformatf("v%0d rsp_nack", vi), 32'(rsp[9]), 32'(v.exp_nack));
        check($sformatf("v%0d rsp_timeout", vi), 32'(rsp[8]), 32'(v.exp_to));
        check($sformatf("v%0d rsp_rdata", vi), 32'(rsp[7:0]), 32'(v.exp_rdata));
        // Bus condition trace: START, bytes, optional repeated START, bytes, STOP.
        if (v.rw) exp_keys = '{7, 5, 0, 4, 6, 7, 5, 0, 5, 7, 6};
        else      exp_keys = '{7, 5, 0, 5, 7, 6};
        check($sformatf("v%0d segment count", vi), 32'(seg_q.size()), 32'(exp_keys.size()));
        n = (seg_q.size() < exp_keys.size()) ? seg_q.size() : exp_keys.size();
        for (int i = 0; i < n; i++) begin
            nm = $sformatf("v%0d seg%0d", vi, i);
            check({nm, " key"}, 32'(seg_q[i].key), 32'(exp_keys[i]));
            if (exp_keys[i] != 0) begin
                check({nm, " len"}, 32'(seg_q[i].len), 32'(HALF_PERIOD));
            end else if (v.hang) begin
                check({nm, " abort window"},
                      32'(seg_q[i].len >= BYTE_TIMEOUT && seg_q[i].len <= BYTE_TIMEOUT + 10),
                      32'd1);
            end
        end
        // Bytes handed to the engine, and which bus-released window each fell in.
        check($sformatf("v%0d byte count", vi), 32'(byte_q.size()), 32'(v.exp_nbytes));
        n = (byte_q.size() < v.exp_nbytes) ? byte_q.size() : v.exp_nbytes;
        for (int i = 0; i < n; i++) begin
            nm = $sformatf("v%0d byte%0d", vi, i);
            if (v.exp_bytes[i][8]) check({nm, " mode/data"}, 32'(byte_q[i].val), 32'(v.exp_bytes[i]));
            else                   check({nm, " mode"}, 32'(byte_q[i].val[8]), 32'd0);
            check({nm, " window"}, 32'(byte_q[i].seg), (v.rw && i >= 2) ? 32'd7 : 32'd2);
        end
        @(negedge clk);
        check($sformatf("v%0d cmd_ready after rsp", vi), 32'(cmd_ready), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        bit         got;
        logic [9:0] rsp;
        int         n;
        int         bus_moves;
        int         rsp_seen;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        drive_cmd(1'b0, 7'h00, 8'h00, 8'h00);

        //               rw    dev    reg    wdata  nack hang early mrd    en to  erd    nb  bytes
        vecs[0] = mk(1'b0, 7'h48, 8'h01, 8'hA5, -1, 0, 0, 8'h00, 0, 0, 8'h00, 3, 9'h190, 9'h101, 9'h1A5, 9'h000);
        vecs[1] = mk(1'b1, 7'h48, 8'h00, 8'h00, -1, 0, 0, 8'h3C, 0, 0, 8'h3C, 4, 9'h190, 9'h100, 9'h191, 9'h000);
        vecs[2] = mk(1'b0, 7'h50, 8'h10, 8'h77,  0, 0, 0, 8'h00, 1, 0, 8'h3C, 1, 9'h1A0, 9'h000, 9'h000, 9'h000);
        vecs[3] = mk(1'b1, 7'h21, 8'h05, 8'h00,  2, 0, 0, 8'h99, 1, 0, 8'h3C, 3, 9'h142, 9'h105, 9'h143, 9'h000);
        vecs[4] = mk(1'b0, 7'h7F, 8'hFF, 8'h00,  2, 0, 0, 8'h00, 1, 0, 8'h3C, 3, 9'h1FE, 9'h1FF, 9'h100, 9'h000);
        vecs[5] = mk(1'b1, 7'h0A, 8'h80, 8'h00, -1, 0, 1, 8'hC3, 0, 0, 8'hC3, 4, 9'h114, 9'h180, 9'h115, 9'h000);
        vecs[6] = mk(1'b0, 7'h33, 8'h44, 8'h55, -1, 1, 0, 8'h00, 1, 1, 8'hC3, 1, 9'h166, 9'h000, 9'h000, 9'h000);

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset rsp flags", 32'({rsp_valid, rsp_nack, rsp_timeout}), 32'd0);
        check("reset engine outputs", 32'({eng_start, eng_mode_w_r, eng_data}), 32'd0);
        check("reset rsp_rdata", 32'(rsp_rdata), 32'h00);
        check("reset bus", 32'({bus_own, bus_scl, bus_sda_low}), 32'b110);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset in the middle of the register byte: immediate return to idle, no STOP.
        model_nack_idx = -1; model_hang = 1'b0; model_early = 1'b0; model_byte_cnt = 0;
        @(negedge clk);
        drive_cmd(1'b0, 7'h48, 8'h02, 8'h11);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 5000 && !got; c++) begin
            @(negedge clk);
            if (model_byte_cnt == 2) got = 1'b1;
        end
        check("mid reset reached reg byte", 32'(got), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid reset bus released", 32'({bus_own, bus_scl, bus_sda_low}), 32'b110);
        check("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid reset no rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid reset rsp_rdata", 32'(rsp_rdata), 32'h00);
        reset_n = 1'b1;
        bus_moves = 0;
        rsp_seen  = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ({bus_own, bus_scl, bus_sda_low} != 3'b110) bus_moves++;
            if (rsp_valid) rsp_seen++;
        end
        check("post reset bus quiet", 32'(bus_moves), 32'd0);
        check("post reset no response", 32'(rsp_seen), 32'd0);

        // Back-to-back with cmd_valid held; fields changed mid-transaction must not be captured.
        model_byte_cnt = 0;
        @(negedge clk);
        drive_cmd(1'b0, 7'h12, 8'h34, 8'h56);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 mon_start();
        repeat (50) @(negedge clk);
        drive_cmd(1'b0, 7'h22, 8'h44, 8'h66);
        wait_rsp("b2b first", got, rsp);
        if (got) begin
            check("b2b first nack", 32'(rsp[9]), 32'd0);
            check("b2b first byte count", 32'(byte_q.size()), 32'd3);
            if (byte_q.size() == 3) begin
                check("b2b first addr", 32'(byte_q[0].val), 32'h124);
                check("b2b first reg", 32'(byte_q[1].val), 32'h134);
                check("b2b first data", 32'(byte_q[2].val), 32'h156);
            end
            @(negedge clk);
            check("b2b ready one cycle after rsp", 32'(cmd_ready), 32'd1);
            @(posedge clk);
            #1 mon_start();
            @(negedge clk);
            check("b2b accepted", 32'(cmd_ready), 32'd0);
            cmd_valid = 1'b0;
            wait_rsp("b2b second", got, rsp);
            if (got) begin
                check("b2b second nack", 32'(rsp[9]), 32'd0);
                check("b2b second seg count", 32'(seg_q.size()), 32'd6);
                if (seg_q.size() >= 2) begin
                    check("b2b S1 key", 32'(seg_q[0].key), 32'd7);
                    check("b2b S1 len", 32'(seg_q[0].len), 32'(HALF_PERIOD));
                    check("b2b S2 key", 32'(seg_q[1].key), 32'd5);
                    check("b2b S2 len", 32'(seg_q[1].len), 32'(HALF_PERIOD));
                end
                n = byte_q.size();
                check("b2b second byte count", 32'(n), 32'd3);
                if (n == 3) begin
                    check("b2b second addr", 32'(byte_q[0].val), 32'h144);
                    check("b2b second reg", 32'(byte_q[1].val), 32'h144);
                    check("b2b second data", 32'(byte_q[2].val), 32'h166);
                end
            end
        end
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #(64'd100000 * 20);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Transaction sequencer directly upstream of the I2C byte engine; the engine clocks one byte per start pulse.
- Accepts one register-access command: write {dev, reg, data} or read {dev, reg} returning one byte.
- Generates START, repeated-START and STOP bus conditions itself and issues each byte to the engine.
- Checks ACK after every written byte and returns a single response.

Parameters:
- HALF_PERIOD, 350: clk cycles per bus-condition phase (7 us at 50 MHz, matches engine SCL phase).
- BYTE_TIMEOUT, 20000: max clk cycles waiting on one engine byte before abort.

Ports:
- clk in 1: 50 MHz system clock.
- reset_n in 1: synchronous active-low reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: high only in IDLE; handshake completes when cmd_valid & cmd_ready.
- cmd_rw in 1: 1 = register read, 0 = register write.
- cmd_dev_addr in 7: 7-bit device address.
- cmd_reg_addr in 8: register address.
- cmd_wdata in 8: write data.
- rsp_valid out 1: one-cycle pulse on completion.
- rsp_rdata out 8: read byte, held until next rsp_valid.
- rsp_nack out 1: qualified by rsp_valid; set on NACK or timeout.
- rsp_timeout out 1: qualified by rsp_valid; set on timeout only.
- eng_start out 1: one-cycle start pulse to engine.
- eng_mode_w_r out 1: 1 = engine writes byte, 0 = engine reads byte.
- eng_data out 8: byte for engine to send.
- eng_read_data in 8: byte received by engine.
- eng_receive_ack in 1: SDA sampled in ACK slot; 0 = ACK.
- eng_idle in 1: engine idle.
- bus_own out 1: 1 = sequencer drives bus; top-level mux selects bus_scl/bus_sda_low over the engine.
- bus_scl out 1: SCL level while bus_own.
- bus_sda_low out 1: 1 pulls SDA low (open drain) while bus_own.

Behaviour:
- Reset (reset_n = 0 at posedge clk): state IDLE; cmd_ready=1; rsp_valid, rsp_nack, rsp_timeout, eng_start, eng_mode_w_r=0; eng_data, rsp_rdata=0x00; bus_own=1, bus_scl=1, bus_sda_low=0 (bus released/idle). Reset mid-transaction aborts immediately; no STOP is generated.
- Command capture: on the handshake, latch all cmd_* fields; cmd_ready drops the next cycle.
- Phase timing: each condition phase holds outputs for exactly HALF_PERIOD cycles.
- START sequence:
  - S1: SCL=1, SDA low.
  - S2: SCL=0, SDA low.
  - Then bus_own=0.
- Byte sequence:
  - Write transaction: ADDR (dev,0) -> REG -> DATA -> STOP.
  - Read transaction: ADDR (dev,0) -> REG -> RSTART -> ADDR (dev,1) -> READ -> STOP.
- Byte sub-FSM (ISSUE -> WAIT_BUSY -> WAIT_DONE):
  - ISSUE: eng_data/eng_mode_w_r set the cycle before eng_start and held stable until WAIT_DONE exits; eng_start=1 for one cycle.
  - WAIT_BUSY: wait for eng_idle=0.
  - WAIT_DONE: wait for eng_idle=1.
  - Byte timeout counter counts across WAIT_BUSY+WAIT_DONE; reaching BYTE_TIMEOUT -> abort.
- ACK check:
  - After each written byte, sample eng_receive_ack on the cycle eng_idle returns high.
  - 1 -> set nack flag, skip remaining bytes, go to STOP.
- READ byte: eng_mode_w_r=0; capture eng_read_data into rsp_rdata when eng_idle returns high. The engine generates the master NACK; the sequencer ignores eng_receive_ack here.
- RSTART sequence (bus_own=1):
  - R1: SCL=0, SDA released.
  - R2: SCL=1, SDA released.
  - R3: SCL=1, SDA low.
  - R4: SCL=0, SDA low.
- STOP sequence (bus_own=1), always executed, including after NACK/timeout:
  - P1: SCL=0, SDA low.
  - P2: SCL=1, SDA low.
  - P3: SCL=1, SDA released.
  - Then DONE.
- DONE: rsp_valid=1 for one cycle with rsp_nack/rsp_timeout; return to IDLE next cycle with cmd_ready=1. A cmd_valid held high is accepted one cycle after rsp_valid at the earliest.
- Boundaries:
  - cmd_valid while busy: ignored, no capture.
  - eng_idle already low at ISSUE: treated as busy seen.
  - A timeout also sets rsp_nack.
  - rsp_rdata is unchanged on a write or an aborted read.
- Counters: phase counter 9 bits min; timeout counter ceil(log2(BYTE_TIMEOUT+1)) bits; saturate, no wrap.

Test Plan:
- Write dev 0x48, reg 0x01, data 0xA5, engine model ACKs all -> eng_data sequence 0x90, 0x01, 0xA5 (mode 1); START then STOP observed; rsp_valid with rsp_nack=0.
- Read dev 0x48, reg 0x00, model returns 0x3C -> eng_data 0x90, 0x00, RSTART, 0x91, then mode 0 byte; rsp_rdata=0x3C, rsp_nack=0.
- Write with model NACK on address byte -> only one eng_start; STOP follows; rsp_nack=1, rsp_timeout=0.
- Engine model never leaves idle after eng_start -> abort after BYTE_TIMEOUT cycles; STOP generated; rsp_nack=1, rsp_timeout=1.
- Assert reset_n=0 during REG byte -> next cycle bus_own=1, bus_scl=1, bus_sda_low=0, cmd_ready=1, no rsp_valid.
- Back-to-back commands with cmd_valid held high -> second accepted exactly one cycle after the first rsp_valid; START phase lengths each equal 350 cycles.
